bus_xfer_ctrl: RTL and testbench

Bus transfer sequencer that drives the shared 16-bit register bus from the control side. It accepts one transfer request at a time and issues one-hot `read` and `write` strobes to the register file (R0..R7), so at most one register drives the bus in any cycle. It can also drive the bus itself for immediate and clear operations. It sits between the instruction decode/control FSM and the register file, and performs every register-to-register move the CPU needs.

---
 rtl/bus_xfer_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// Register-bus transfer sequencer: MOV/LDI/CLR/SWAP via one-hot read/write strobes.
// Define BUS_XFER_SWAP_EN to build SWAP support; otherwise every SWAP is rejected.
module bus_xfer_ctrl #(
    parameter int unsigned NREG    = 8,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TMP_IDX = 7,
    localparam int unsigned IW     = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [IW-1:0]    req_src,
    input  logic [IW-1:0]    req_dst,
    input  logic [WIDTH-1:0] req_imm,
    output logic [NREG-1:0]  read_en,
    output logic [NREG-1:0]  write_en,
    output logic [WIDTH-1:0] bus_drive,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [IW-1:0] TMP = IW'(TMP_IDX);

    typedef enum logic [1:0] {
        OP_MOV  = 2'b00,
        OP_LDI  = 2'b01,
        OP_SWAP = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

`ifdef BUS_XFER_SWAP_EN
    typedef enum logic [2:0] {S_IDLE, S_X1, S_X2, S_X3, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_X1, S_ERR} state_t;
`endif

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [IW-1:0]    src_q, src_d, dst_q, dst_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic             swap_ok;

    logic [NREG-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [WIDTH-1:0] drv_q, drv_d;
    logic             drv_en_q, drv_en_d;
    logic             done_q, done_d, err_q, err_d, ready_q, ready_d, busy_q, busy_d;

    function automatic logic [NREG-1:0] onehot(input logic [IW-1:0] idx);
        return NREG'(1) << idx;
    endfunction

`ifdef BUS_XFER_SWAP_EN
    assign swap_ok = (req_src != TMP) && (req_dst != TMP);
`else
    assign swap_ok = 1'b0;
`endif

    // Next state, latched fields, and outputs decoded from the next registered values
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_d    = src_q;
        dst_d    = dst_q;
        imm_d    = imm_q;
        rd_d     = '0;
        wr_d     = '0;
        drv_en_d = 1'b0;
        drv_d    = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d  = op_t'(req_op);
                    src_d = req_src;
                    dst_d = req_dst;
                    imm_d = req_imm;
                    if (op_t'(req_op) == OP_SWAP) state_d = swap_ok ? S_X1 : S_ERR;
                    else                          state_d = S_X1;
                end
            end
`ifdef BUS_XFER_SWAP_EN
            S_X1:    state_d = (op_q == OP_SWAP) ? S_X2 : S_IDLE;
            S_X2:    state_d = S_X3;
            S_X3:    state_d = S_IDLE;
`else
            S_X1:    state_d = S_IDLE;
`endif
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_X1: begin
                case (op_d)
                    OP_MOV: begin
                        rd_d   = onehot(src_d);
                        wr_d   = onehot(dst_d);
                        done_d = 1'b1;
                    end
                    OP_LDI: begin
                        drv_en_d = 1'b1;
                        drv_d    = imm_d;
                        wr_d     = onehot(dst_d);
                        done_d   = 1'b1;
                    end
                    OP_CLR: begin
                        drv_en_d = 1'b1;
                        wr_d     = onehot(dst_d);
                        done_d   = 1'b1;
                    end
                    OP_SWAP: begin
                        rd_d = onehot(src_d);
                        wr_d = onehot(TMP);
                    end
                    default: ;
                endcase
            end
`ifdef BUS_XFER_SWAP_EN
            S_X2: begin
                rd_d = onehot(dst_d);
                wr_d = onehot(src_d);
            end
            S_X3: begin
                rd_d   = onehot(TMP);
                wr_d   = onehot(dst_d);
                done_d = 1'b1;
            end
`endif
            S_ERR:   err_d = 1'b1;
            default: ;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MOV;
            src_q    <= '0;
            dst_q    <= '0;
            imm_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            drv_q    <= '0;
            drv_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            imm_q    <= imm_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            drv_q    <= drv_d;
            drv_en_q <= drv_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign read_en   = rd_q;
    assign write_en  = wr_q;
    assign bus_drive = drv_en_q ? drv_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: behavioural register file on the bus plus an array model of the registers.
module tb_bus_xfer_ctrl;

    localparam int unsigned NREG  = 8;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned IW    = 3;
    localparam int unsigned TMP   = 7;
`ifdef BUS_XFER_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [IW-1:0]    req_src;
    logic [IW-1:0]    req_dst;
    logic [WIDTH-1:0] req_imm;
    logic [NREG-1:0]  read_en;
    logic [NREG-1:0]  write_en;
    wire  [WIDTH-1:0] bus_drive;
    logic             busy;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.NREG(NREG), .WIDTH(WIDTH), .TMP_IDX(TMP)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_imm   (req_imm),
        .read_en   (read_en),
        .write_en  (write_en),
        .bus_drive (bus_drive),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Register file hanging off the bus
    logic [WIDTH-1:0] rf [NREG];
    logic [WIDTH-1:0] bus_val;

    always_comb begin
        bus_val = bus_drive;
        for (int i = 0; i < NREG; i++) if (read_en[i]) bus_val = rf[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) if (write_en[i]) rf[i] <= bus_val;
    end

    logic [WIDTH-1:0] m [NREG];
    logic [NREG-1:0]  known = '0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NREG; i++)
            if (known[i]) chk($sformatf("%s_R%0d", tag, i), 32'(rf[i]), 32'(m[i]));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(busy),      32'(0));
        chk({tag, "_ready"}, 32'(req_ready), 32'(1));
        chk({tag, "_rd"},    32'(read_en),   32'(0));
        chk({tag, "_wr"},    32'(write_en),  32'(0));
        chk({tag, "_done"},  32'(done),      32'(0));
        chk({tag, "_err"},   32'(err),       32'(0));
    endtask

    // One complete request: expected strobe cycles, then register contents
    task automatic xfer(input logic [1:0] op, input logic [IW-1:0] s, input logic [IW-1:0] d,
                        input logic [WIDTH-1:0] imm);
        int               n;
        logic             rej;
        logic [NREG-1:0]  er [3];
        logic [NREG-1:0]  ew [3];
        logic             ed [3];
        logic             ee [3];
        logic             edrv [3];
        logic [WIDTH-1:0] ev [3];
        logic [WIDTH-1:0] t;
        for (int k = 0; k < 3; k++) begin
            er[k] = '0; ew[k] = '0; ed[k] = 1'b0; ee[k] = 1'b0; edrv[k] = 1'b0; ev[k] = '0;
        end
        rej = (op == 2'b10) && (!SWAP_EN || s == IW'(TMP) || d == IW'(TMP));
        if (rej) begin
            n = 1; ee[0] = 1'b1;
        end else if (op == 2'b10) begin
            n = 3;
            er[0] = NREG'(1) << s;   ew[0] = NREG'(1) << TMP;
            er[1] = NREG'(1) << d;   ew[1] = NREG'(1) << s;
            er[2] = NREG'(1) << TMP; ew[2] = NREG'(1) << d; ed[2] = 1'b1;
        end else begin
            n = 1; ew[0] = NREG'(1) << d; ed[0] = 1'b1;
            if (op == 2'b00) er[0] = NREG'(1) << s;
            else begin
                edrv[0] = 1'b1;
                ev[0]   = (op == 2'b01) ? imm : '0;
            end
        end

        @(negedge clk);
        chk("ready_pre", 32'(req_ready), 32'(1));
        req_valid = 1'b1; req_op = op; req_src = s; req_dst = d; req_imm = imm;
        @(posedge clk); #1;
        // Keep a garbage request asserted; it must be ignored while busy
        req_op  = 2'($urandom); req_src = IW'($urandom);
        req_dst = IW'($urandom); req_imm = WIDTH'($urandom);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            chk($sformatf("rd_c%0d", k),    32'(read_en),   32'(er[k]));
            chk($sformatf("wr_c%0d", k),    32'(write_en),  32'(ew[k]));
            chk($sformatf("done_c%0d", k),  32'(done),      32'(ed[k]));
            chk($sformatf("err_c%0d", k),   32'(err),       32'(ee[k]));
            chk($sformatf("busy_c%0d", k),  32'(busy),      32'(1));
            chk($sformatf("ready_c%0d", k), 32'(req_ready), 32'(0));
            if (edrv[k]) chk("bus_drive", 32'(bus_drive), 32'(ev[k]));
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk_idle("post");

        if (!rej) begin
            case (op)
                2'b00: m[d] = m[s];
                2'b01: m[d] = imm;
                2'b11: m[d] = '0;
                default: begin
                    t = m[s]; m[TMP] = t; m[s] = m[d]; m[d] = t;
                    known[TMP] = 1'b1;
                end
            endcase
            known[d] = 1'b1;
        end
        chk_regs("regs");
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src = '0; req_dst = '0; req_imm = '0;
        #1;
        chk_idle("reset");
        #13;
        @(negedge clk); reset = 1'b0;

        // Preload every register
        for (int i = 0; i < NREG; i++) xfer(2'b01, '0, IW'(i), WIDTH'($urandom));

        xfer(2'b01, 3'd0, 3'd2, 16'hA5A5);
        xfer(2'b00, 3'd2, 3'd5, 16'h0000);
        chk("mov_r5", 32'(rf[5]), 32'h0000A5A5);
        xfer(2'b01, 3'd0, 3'd3, 16'h1234);
        xfer(2'b11, 3'd0, 3'd3, 16'hFFFF);
        xfer(2'b00, 3'd6, 3'd6, 16'h0000);

        xfer(2'b01, 3'd0, 3'd1, 16'h0001);
        xfer(2'b01, 3'd0, 3'd4, 16'h0004);
        xfer(2'b10, 3'd1, 3'd4, 16'h0000);
        xfer(2'b10, 3'd2, 3'd7, 16'h0000);
        xfer(2'b10, 3'd7, 3'd3, 16'h0000);

        // Reset in the middle of an operation
        xfer(2'b01, 3'd0, 3'd1, 16'h1111);
        xfer(2'b01, 3'd0, 3'd4, 16'h4444);
        @(negedge clk);
`ifdef BUS_XFER_SWAP_EN
        req_valid = 1'b1; req_op = 2'b10; req_src = 3'd1; req_dst = 3'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("swp_x1_rd", 32'(read_en), 32'h02);
        @(posedge clk); #1;
        chk("swp_x2_rd", 32'(read_en), 32'h10);
        m[TMP] = m[1];
`else
        req_valid = 1'b1; req_op = 2'b01; req_src = 3'd0; req_dst = 3'd1; req_imm = 16'hBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ldi_x1_wr", 32'(write_en), 32'h02);
`endif
        #2 reset = 1'b1;
        #1;
        chk_idle("midrst");
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk_regs("midrst");
        xfer(2'b00, 3'd4, 3'd2, 16'h0000);

        // Reset and request together: request dropped
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b1; req_op = 2'b01; req_dst = 3'd5; req_imm = 16'hDEAD;
        @(posedge clk); #1;
        chk_idle("rstreq");
        @(negedge clk); req_valid = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        chk_idle("rstreq_after");
        chk_regs("rstreq");

        for (int i = 0; i < 40; i++)
            xfer(2'($urandom_range(0, 3)), IW'($urandom), IW'($urandom), WIDTH'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
